// File: rtl/alu_seq_pkg.sv
// Shared constants and state encoding for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ADC  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam logic [15:0] IDLE_A = 16'hFFFF;
  localparam logic [15:0] IDLE_B = 16'h0000;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } seq_state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: async-low reset, two combinational read ports, one synchronous write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned NRegs = 8,
  parameter int unsigned Width = 16,
  localparam int unsigned AddrW = $clog2(NRegs)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [Width-1:0] rdata_a_o,
  output logic [Width-1:0] rdata_b_o
);

  logic [Width-1:0] rf_q [NRegs];
  logic [Width-1:0] rf_d [NRegs];

  always_comb begin
    rf_d = rf_q;
    if (we_i) begin
      rf_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NRegs); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rdata_a_o = rf_q[raddr_a_i];
  assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit AU: register-file operand fetch, writeback and result port.
// Optional accepted-command counter output enabled by ALU_SEQ_CMD_COUNT_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [1:0]       iCmdOp,
  input  logic [AW-1:0]    iCmdDst,
  input  logic [AW-1:0]    iCmdSrcA,
  input  logic [AW-1:0]    iCmdSrcB,
  input  logic [WIDTH-1:0] iCmdImm,
  output logic [WIDTH-1:0] oPortA,
  output logic [WIDTH-1:0] oPortB,
  output logic [1:0]       oOpcode,
  input  logic [WIDTH-1:0] iAccumulator,
  input  logic             iCarryFlag,
  input  logic             iZeroFlag,
  output logic             oResValid,
  input  logic             iResReady,
  output logic [WIDTH-1:0] oResData,
  output logic [AW-1:0]    oResDst,
  output logic             oResZero,
  output logic             oResCarry
`ifdef ALU_SEQ_CMD_COUNT_EN
  ,
  output logic [15:0]      oCmdCount
`endif
);

  seq_state_e       state_q, state_d;
  logic             accept;
  logic             is_load;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] wr_data;
  logic             wr_zero;

  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [AW-1:0]    res_dst_q, res_dst_d;
  logic             res_zero_q, res_zero_d;

  assign oCmdReady = (state_q == StEmpty) | iResReady;
  assign accept    = iCmdValid & oCmdReady;
  assign is_load   = (iCmdOp == OP_LOAD);

  alu_seq_regfile #(
    .NRegs (NREGS),
    .Width (WIDTH)
  ) u_regfile (
    .clk_i     (iClock),
    .rst_ni    (iReset),
    .we_i      (accept),
    .waddr_i   (iCmdDst),
    .wdata_i   (wr_data),
    .raddr_a_i (iCmdSrcA),
    .raddr_b_i (iCmdSrcB),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  // Idle stimulus makes the AU compute FFFF+cin, so its carry flop holds its value.
  always_comb begin
    oPortA  = WIDTH'(IDLE_A);
    oPortB  = WIDTH'(IDLE_B);
    oOpcode = OP_ADC;
    if (accept && !is_load) begin
      oPortA  = rd_a;
      oPortB  = rd_b;
      oOpcode = iCmdOp;
    end
  end

  assign wr_data = is_load ? iCmdImm : iAccumulator;
  assign wr_zero = is_load ? (iCmdImm == '0) : iZeroFlag;

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_dst_d  = res_dst_q;
    res_zero_d = res_zero_q;
    case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (iResReady && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (accept) begin
      res_data_d = wr_data;
      res_dst_d  = iCmdDst;
      res_zero_d = wr_zero;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q    <= StEmpty;
      res_data_q <= '0;
      res_dst_q  <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_dst_q  <= res_dst_d;
      res_zero_q <= res_zero_d;
    end
  end

  assign oResValid = (state_q == StFull);
  assign oResData  = res_data_q;
  assign oResDst   = res_dst_q;
  assign oResZero  = res_zero_q;
  // The AU carry flop serves as the result carry register; it only changes on execute edges.
  assign oResCarry = oResValid & iCarryFlag;

`ifdef ALU_SEQ_CMD_COUNT_EN
  logic [15:0] cmd_count_q, cmd_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    if (accept) begin
      cmd_count_d = cmd_count_q + 16'd1;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      cmd_count_q <= '0;
    end else begin
      cmd_count_q <= cmd_count_d;
    end
  end

  assign oCmdCount = cmd_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an AU model and a result scoreboard.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iCmdValid, oCmdReady;
  logic [1:0]  iCmdOp;
  logic [2:0]  iCmdDst, iCmdSrcA, iCmdSrcB;
  logic [15:0] iCmdImm;
  logic [15:0] oPortA, oPortB;
  logic [1:0]  oOpcode;
  logic [15:0] acc;
  logic        au_carry_q, au_zero;
  logic        oResValid, iResReady;
  logic [15:0] oResData;
  logic [2:0]  oResDst;
  logic        oResZero, oResCarry;
`ifdef ALU_SEQ_CMD_COUNT_EN
  logic [15:0] oCmdCount;
`endif

  always #5 clk = ~clk;

  alu_cmd_sequencer u_dut (
    .iClock       (clk),
    .iReset       (rst_n),
    .iCmdValid    (iCmdValid),
    .oCmdReady    (oCmdReady),
    .iCmdOp       (iCmdOp),
    .iCmdDst      (iCmdDst),
    .iCmdSrcA     (iCmdSrcA),
    .iCmdSrcB     (iCmdSrcB),
    .iCmdImm      (iCmdImm),
    .oPortA       (oPortA),
    .oPortB       (oPortB),
    .oOpcode      (oOpcode),
    .iAccumulator (acc),
    .iCarryFlag   (au_carry_q),
    .iZeroFlag    (au_zero),
    .oResValid    (oResValid),
    .iResReady    (iResReady),
    .oResData     (oResData),
    .oResDst      (oResDst),
    .oResZero     (oResZero),
    .oResCarry    (oResCarry)
`ifdef ALU_SEQ_CMD_COUNT_EN
    ,
    .oCmdCount    (oCmdCount)
`endif
  );

  // Arithmetic unit model: combinational accumulator, registered carry.
  logic [16:0] au_sum;
  always_comb begin
    au_sum = '0;
    case (oOpcode)
      OP_ADD:  au_sum = {1'b0, oPortA} + {1'b0, oPortB};
      OP_ADC:  au_sum = {1'b0, oPortA} + {1'b0, oPortB} + {16'd0, au_carry_q};
      OP_SUB:  au_sum = {1'b0, oPortA - oPortB};
      default: au_sum = {1'b0, oPortA};
    endcase
  end
  assign acc     = au_sum[15:0];
  assign au_zero = (acc == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) au_carry_q <= 1'b0;
    else        au_carry_q <= au_sum[16];
  end

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dst;
    logic        zero;
    logic        carry;
  } res_t;

  res_t        exp_q[$];
  int          pop_cyc[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] rf_m [8];
  logic        carry_m;

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every cycle the consumer takes a result.
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst_n && oResValid && iResReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", 32'(oResData), 32'(e.data));
        chk("res_dst", 32'(oResDst), 32'(e.dst));
        chk("res_zero", 32'(oResZero), 32'(e.zero));
        chk("res_carry", 32'(oResCarry), 32'(e.carry));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] a,
                           input logic [2:0] b, input logic [15:0] imm);
    iCmdValid = 1'b1;
    iCmdOp    = op;
    iCmdDst   = dst;
    iCmdSrcA  = a;
    iCmdSrcB  = b;
    iCmdImm   = imm;
  endtask

  // Waits for acceptance, checks AU drive, predicts the result and pushes it.
  task automatic finish_cmd(output int waits);
    res_t        e;
    logic [16:0] s;
    waits = 0;
    @(negedge clk);
    while (!oCmdReady && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!oCmdReady) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (iCmdOp == OP_LOAD) begin
        chk("load_port_a", 32'(oPortA), 32'h0000FFFF);
        chk("load_port_b", 32'(oPortB), 32'h0);
        chk("load_opcode", 32'(oOpcode), 32'(OP_ADC));
        e.data = iCmdImm;
      end else begin
        chk("exec_port_a", 32'(oPortA), 32'(rf_m[iCmdSrcA]));
        chk("exec_port_b", 32'(oPortB), 32'(rf_m[iCmdSrcB]));
        chk("exec_opcode", 32'(oOpcode), 32'(iCmdOp));
        case (iCmdOp)
          OP_ADD:  s = {1'b0, rf_m[iCmdSrcA]} + {1'b0, rf_m[iCmdSrcB]};
          OP_ADC:  s = {1'b0, rf_m[iCmdSrcA]} + {1'b0, rf_m[iCmdSrcB]} + {16'd0, carry_m};
          default: s = {1'b0, rf_m[iCmdSrcA] - rf_m[iCmdSrcB]};
        endcase
        e.data  = s[15:0];
        carry_m = s[16];
      end
      e.dst   = iCmdDst;
      e.zero  = (e.data == 16'd0);
      e.carry = carry_m;
      rf_m[iCmdDst] = e.data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    iCmdValid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] a,
                      input logic [2:0] b, input logic [15:0] imm, output int waits);
    drive_cmd(op, dst, a, b, imm);
    finish_cmd(waits);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int total_w;
    rst_n     = 1'b0;
    iCmdValid = 1'b0;
    iResReady = 1'b1;
    drive_cmd(OP_LOAD, 3'd0, 3'd0, 3'd0, 16'd0);
    iCmdValid = 1'b0;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;
    carry_m = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(oResValid), 32'd0);
    chk("rst_res_data", 32'(oResData), 32'd0);
    chk("rst_res_dst", 32'(oResDst), 32'd0);
    chk("rst_res_zero", 32'(oResZero), 32'd0);
    chk("rst_res_carry", 32'(oResCarry), 32'd0);
    chk("rst_cmd_ready", 32'(oCmdReady), 32'd1);
    chk("rst_idle_a", 32'(oPortA), 32'h0000FFFF);
    chk("rst_idle_b", 32'(oPortB), 32'd0);
    chk("rst_idle_op", 32'(oOpcode), 32'(OP_ADC));
`ifdef ALU_SEQ_CMD_COUNT_EN
    chk("rst_cmd_count", 32'(oCmdCount), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic LOAD/ADD; the trailing ADD reads r3 back through the operand port
    send(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'h0005, w);
    send(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h0003, w);
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd0, w);
    send(OP_ADD, 3'd0, 3'd3, 3'd0, 16'd0, w);

    // Carry out of an ADD survives idle cycles into an ADC
    send(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'hFFFF, w);
    send(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h0001, w);
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd0, w);
    idle(3);
    chk("idle_opcode", 32'(oOpcode), 32'(OP_ADC));
    send(OP_ADC, 3'd4, 3'd2, 3'd2, 16'd0, w);

    // SUB after a carry-producing ADD clears carry
    send(OP_ADD, 3'd3, 3'd1, 3'd2, 16'd0, w);
    send(OP_SUB, 3'd5, 3'd2, 3'd2, 16'd0, w);
    idle(2);

    // Backpressure: result held, command blocked, carry kept
    send(OP_ADD, 3'd6, 3'd1, 3'd2, 16'd0, w);
    iResReady = 1'b0;
    drive_cmd(OP_LOAD, 3'd7, 3'd0, 3'd0, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_cmd_ready", 32'(oCmdReady), 32'd0);
      chk("stall_res_valid", 32'(oResValid), 32'd1);
      chk("stall_res_data", 32'(oResData), 32'd0);
      chk("stall_res_dst", 32'(oResDst), 32'd6);
      chk("stall_res_zero", 32'(oResZero), 32'd1);
      chk("stall_res_carry", 32'(oResCarry), 32'd1);
    end
    @(posedge clk);
    #1;
    iResReady = 1'b1;
    finish_cmd(w);
    chk("stall_release_waits", 32'(w), 32'd0);
    idle(2);
    chk("drained", 32'(exp_q.size()), 32'd0);

    // Reset during an accepted ADD r5 = r1 + r1
    drive_cmd(OP_ADD, 3'd5, 3'd1, 3'd1, 16'd0);
    @(negedge clk);
    chk("pre_rst_ready", 32'(oCmdReady), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(oResValid), 32'd0);
    chk("midrst_res_data", 32'(oResData), 32'd0);
    chk("midrst_res_carry", 32'(oResCarry), 32'd0);
    @(posedge clk);
    #1;
    iCmdValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;
    carry_m = 1'b0;
    idle(1);
    chk("post_rst_res_valid", 32'(oResValid), 32'd0);

    // 8 back-to-back ADDs; operand checks confirm every register was cleared
    pop_cyc.delete();
    total_w = 0;
    for (int i = 0; i < 8; i++) begin
      send(OP_ADD, 3'(i), 3'(i), 3'(i), 16'd0, w);
      total_w += w;
    end
    idle(2);
    chk("b2b_stalls", 32'(total_w), 32'd0);
    chk("b2b_results", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) chk("b2b_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
`ifdef ALU_SEQ_CMD_COUNT_EN
    chk("cmd_count", 32'(oCmdCount), 32'd8);
`endif
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 16-bit arithmetic unit.
- Accepts register-addressed commands over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the AU operand and opcode ports for exactly one cycle per command.
- Writes the AU accumulator back to the register file and presents each result, with flags, on a registered result port that supports backpressure.

Parameters:
- NREGS, 8, register-file depth; a power of two; address width is log2(NREGS).
- WIDTH, 16, datapath width; must match the AU.

Ports:
- iClock  in  1  system clock, rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iCmdValid  in  1  command valid.
- oCmdReady  out  1  command accepted on the edge where iCmdValid & oCmdReady.
- iCmdOp  in  2  00 LOAD, 01 ADD, 10 ADC, 11 SUB.
- iCmdDst  in  3  destination register.
- iCmdSrcA  in  3  operand A register.
- iCmdSrcB  in  3  operand B register.
- iCmdImm  in  16  immediate, used by LOAD only.
- oPortA  out  16  to AU iPortA.
- oPortB  out  16  to AU iPortB.
- oOpcode  out  2  to AU iOpcode.
- iAccumulator  in  16  from AU oAccumulator (combinational).
- iCarryFlag  in  1  from AU registered carry flag.
- iZeroFlag  in  1  from AU zero flag (combinational).
- oResValid  out  1  result register holds an unconsumed result.
- iResReady  in  1  consumer accepts the result.
- oResData  out  16  result value.
- oResDst  out  3  destination register of the result.
- oResZero  out  1  zero flag of the result.
- oResCarry  out  1  carry produced by the command.

Behaviour:
- Reset (async, iReset=0):
  - All register-file entries = 0.
  - oResValid=0; oResData=0; oResDst=0; oResZero=0; oResCarry=0.
  - State = EMPTY.
  - Port drive = idle stimulus (below).
  - Reset mid-command discards that command; the AU carry flop is reset by the same iReset.
- State machine, two states:
  - EMPTY: result register empty.
  - FULL: result register holds an unconsumed result.
- oCmdReady = (state==EMPTY) | iResReady. A command executes in the same cycle it is accepted.
- Execute cycle (accepted command):
  - oPortA = RF[SrcA]; oPortB = RF[SrcB]; oOpcode = iCmdOp.
  - At the edge, RF[Dst] <= iAccumulator.
  - Result register loads {iAccumulator, Dst, iZeroFlag}.
  - The AU carry flop updates at the same edge. oResCarry is sampled from iCarryFlag one cycle later and is valid whenever oResValid=1.
  - SUB always yields carry 0.
- LOAD (op 00):
  - The AU is not used; port drive = idle stimulus.
  - RF[Dst] <= iCmdImm. Result data = iCmdImm; zero = (iCmdImm==0).
  - Carry is unchanged.
- Idle stimulus, driven on every non-execute cycle and for LOAD: oOpcode=10 (ADC), oPortA=16'hFFFF, oPortB=0.
  - The AU computes FFFF+cin, so carry-out equals carry-in and the AU carry is preserved across stalls and idle cycles.
  - The AU accumulator is ignored in these cycles.
- Consecutive ADD/ADC commands chain carry correctly regardless of gaps or LOADs between them.
- Transitions:
  - EMPTY & accept -> FULL.
  - FULL & iResReady & accept -> FULL, with new result loaded.
  - FULL & iResReady & !accept -> EMPTY.
  - FULL & !iResReady -> FULL, holding the result; oCmdReady=0.
- Hazards:
  - Register-file read is combinational from the current array state.
  - A command reading the register written by the previous command sees the written value; no bypass is needed because writes complete at the edge.
  - Src==Dst is legal.
- Throughput: one command per cycle while iResReady=1.
- Output stability: oRes* are stable while oResValid & !iResReady.

Optional Feature:
- Macro: ALU_SEQ_CMD_COUNT_EN.
- When defined:
  - Adds output oCmdCount[15:0], counting accepted commands.
  - The count wraps FFFF->0 and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_seq_pkg:
  - Opcode constants OP_LOAD=2'b00, OP_ADD=2'b01, OP_ADC=2'b10, OP_SUB=2'b11.
  - Idle stimulus constants IDLE_A=16'hFFFF, IDLE_B=16'h0000.
  - State encoding.
- One natural sub-module: alu_seq_regfile. It holds the 8x16 array with async-low reset, two combinational read ports and one synchronous write port.

Test Plan:
- LOAD r1=0x0005, LOAD r2=0x0003, ADD r3=r1+r2 -> results 0x0005, 0x0003, 0x0008; zero=0; carry=0; RF[3]=0x0008.
- LOAD r1=0xFFFF, r2=0x0001; ADD r3=r1+r2; 3 idle cycles; ADC r4=r2+r2 -> r3 result 0x0000 with zero=1, carry=1; r4=0x0003 (carry preserved across idle).
- SUB r5=r2-r2 after a carry=1 ADD -> result 0x0000, zero=1, carry=0.
- Hold iResReady=0 with a result pending -> oCmdReady=0, oRes* stable for 4 cycles, AU carry unchanged; then iResReady=1 -> next command accepted the same cycle.
- Assert iReset=0 during an accepted ADD -> oResValid=0, all registers 0, carry 0, and no write occurs after release.
- Back-to-back 8 ADDs with iResReady=1 -> 8 results on 8 consecutive cycles; with ALU_SEQ_CMD_COUNT_EN defined, oCmdCount=8.
